// File: rtl/write_full.sv
// Write-side pointer/full stage of the async FIFO: read-pointer synchroniser, write pointer, full/overflow flags.
// Optional almost-full flag is built only when WRITE_FULL_ALMOST_EN is defined.
module write_full #(
  parameter int FIFO_DEPTH_BIT  = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_FULL_GAP = 2
) (
  input  logic                      w_clk,
  input  logic                      w_rst_n,
  input  logic                      w_en,
  input  logic [FIFO_DEPTH_BIT:0]   read_addr_gray,
  output logic                      w_accept,
  output logic [FIFO_DEPTH_BIT-1:0] write_addr,
  output logic [FIFO_DEPTH_BIT:0]   write_addr_gray,
  output logic                      flag_full,
  output logic                      flag_overflow
`ifdef WRITE_FULL_ALMOST_EN
  ,
  output logic                      flag_almost_full
`endif
);

  localparam int PTR_W = FIFO_DEPTH_BIT + 1;
  localparam int MSB   = FIFO_DEPTH_BIT;

  logic [PTR_W-1:0] r_sync [SYNC_STAGES];
  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wgray;
  logic             r_full;
  logic             r_overflow;

  logic [PTR_W-1:0] w_rqSync;
  logic [PTR_W-1:0] w_wbinNext;
  logic [PTR_W-1:0] w_wgrayNext;
  logic [PTR_W-1:0] w_fullTarget;
  logic             w_fullNext;

  assign w_rqSync     = r_sync[SYNC_STAGES-1];
  assign w_accept     = w_en & ~r_full;
  assign w_wbinNext   = r_wbin + {{FIFO_DEPTH_BIT{1'b0}}, w_accept};
  assign w_wgrayNext  = (w_wbinNext >> 1) ^ w_wbinNext;
  // Full when the next write pointer is exactly one lap ahead of the synchronised read pointer.
  assign w_fullTarget = {~w_rqSync[MSB:MSB-1], w_rqSync[MSB-2:0]};
  assign w_fullNext   = (w_wgrayNext == w_fullTarget);

  assign write_addr      = r_wbin[FIFO_DEPTH_BIT-1:0];
  assign write_addr_gray = r_wgray;
  assign flag_full       = r_full;
  assign flag_overflow   = r_overflow;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_sync[0] <= read_addr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_wbin  <= w_wbinNext;
      r_wgray <= w_wgrayNext;
      r_full  <= w_fullNext;
      if (w_en && r_full) r_overflow <= 1'b1;
    end
  end

`ifdef WRITE_FULL_ALMOST_EN
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'((1 << FIFO_DEPTH_BIT) - ALMOST_FULL_GAP);

  logic [PTR_W-1:0] w_rbinSync;
  logic [PTR_W-1:0] w_level;
  logic             r_almostFull;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbinSync = '0;
    for (int i = 0; i < PTR_W; i++) w_rbinSync[i] = ^(w_rqSync >> i);
  end

  assign w_level          = w_wbinNext - w_rbinSync;
  assign flag_almost_full = r_almostFull;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_almostFull <= 1'b0;
    else          r_almostFull <= (w_level >= AF_LEVEL);
  end
`endif

endmodule

// File: tb/tb_write_full.sv
// Self-checking bench for write_full: table-driven fill, hand-written corner sequences, random run vs. occupancy model.
module tb_write_full;

  logic       w_clk;
  logic       w_rst_n;
  logic       w_en;
  logic [4:0] read_addr_gray;
  logic       w_accept;
  logic [3:0] write_addr;
  logic [4:0] write_addr_gray;
  logic       flag_full;
  logic       flag_overflow;
`ifdef WRITE_FULL_ALMOST_EN
  logic       flag_almost_full;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: binary write count, delayed copies of the read count, and the flags derived from occupancy.
  int m_wcnt;
  int m_sync [2];
  bit m_full;
  bit m_ovf;
  bit m_af;

  write_full dut (
    .w_clk           (w_clk),
    .w_rst_n         (w_rst_n),
    .w_en            (w_en),
    .read_addr_gray  (read_addr_gray),
    .w_accept        (w_accept),
    .write_addr      (write_addr),
    .write_addr_gray (write_addr_gray),
    .flag_full       (flag_full),
    .flag_overflow   (flag_overflow)
`ifdef WRITE_FULL_ALMOST_EN
    ,
    .flag_almost_full(flag_almost_full)
`endif
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] toGray(input int b);
    int v;
    v = b % 32;
    return 5'(v ^ (v >> 1));
  endfunction

  function automatic int occupancy(input int w, input int r);
    return (((w - r) % 32) + 32) % 32;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge w_clk);
    w_rst_n        = 1'b0;
    w_en           = 1'b0;
    read_addr_gray = '0;
    m_wcnt = 0; m_sync[0] = 0; m_sync[1] = 0;
    m_full = 0; m_ovf = 0; m_af = 0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
  endtask

  // One write-clock cycle: drive, check the strobe, advance the model on the edge, check registered outputs.
  task automatic applyStimulus(input bit en, input int rp, output bit acc);
    int occ;
    @(negedge w_clk);
    w_en           = en;
    read_addr_gray = toGray(rp);
    #1;
    acc = en && !m_full;
    checkOutput("w_accept", int'(w_accept), int'(acc));
    @(posedge w_clk);
    if (en && m_full) m_ovf = 1;
    m_wcnt = (m_wcnt + int'(acc)) % 32;
    occ    = occupancy(m_wcnt, m_sync[1]);
    m_full = (occ == 16);
    m_af   = (occ >= 14);
    m_sync[1] = m_sync[0];
    m_sync[0] = rp % 32;
    #1;
    checkOutput("write_addr", int'(write_addr), m_wcnt % 16);
    checkOutput("write_addr_gray", int'(write_addr_gray), int'(toGray(m_wcnt)));
    checkOutput("flag_full", int'(flag_full), int'(m_full));
    checkOutput("flag_overflow", int'(flag_overflow), int'(m_ovf));
`ifdef WRITE_FULL_ALMOST_EN
    checkOutput("flag_almost_full", int'(flag_almost_full), int'(m_af));
`endif
  endtask

  typedef struct {
    bit         en;
    int         rp;
    bit         expAccept;
    logic [3:0] expAddr;
    logic [4:0] expGray;
    bit         expFull;
    bit         expAf;
  } vec_t;

  initial begin
    vec_t       vecs [17];
    bit         acc;
    logic [4:0] prevGray;
    int         rp;

    for (int i = 0; i < 16; i++) begin
      vecs[i].en        = 1;
      vecs[i].rp        = 0;
      vecs[i].expAccept = 1;
      vecs[i].expAddr   = 4'((i + 1) % 16);
      vecs[i].expGray   = toGray(i + 1);
      vecs[i].expFull   = (i == 15);
      vecs[i].expAf     = (i >= 13);
    end
    vecs[16] = '{en: 1, rp: 0, expAccept: 0, expAddr: 4'd0, expGray: 5'b11000, expFull: 1, expAf: 1};

    w_rst_n        = 1'b0;
    w_en           = 1'b0;
    read_addr_gray = '0;
    #3;
    checkOutput("reset_addr", int'(write_addr), 0);
    checkOutput("reset_gray", int'(write_addr_gray), 0);
    checkOutput("reset_full", int'(flag_full), 0);
    checkOutput("reset_ovf", int'(flag_overflow), 0);
    applyReset();

    // Fill to full, then one write attempt while full.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].en, vecs[i].rp, acc);
      checkOutput("tbl_accept", int'(acc), int'(vecs[i].expAccept));
      checkOutput("tbl_addr", int'(write_addr), int'(vecs[i].expAddr));
      checkOutput("tbl_gray", int'(write_addr_gray), int'(vecs[i].expGray));
      checkOutput("tbl_full", int'(flag_full), int'(vecs[i].expFull));
`ifdef WRITE_FULL_ALMOST_EN
      checkOutput("tbl_af", int'(flag_almost_full), int'(vecs[i].expAf));
`endif
    end
    checkOutput("ovf_set", int'(flag_overflow), 1);

    // Drain: one read becomes visible three edges after the Gray pointer moves.
    applyStimulus(0, 1, acc);
    checkOutput("drain_e1_full", int'(flag_full), 1);
    applyStimulus(0, 1, acc);
    checkOutput("drain_e2_full", int'(flag_full), 1);
    applyStimulus(0, 1, acc);
    checkOutput("drain_e3_full", int'(flag_full), 0);
    checkOutput("drain_addr", int'(write_addr), 0);
    applyStimulus(1, 1, acc);
    checkOutput("drain_accept", int'(acc), 1);
    checkOutput("ovf_sticky", int'(flag_overflow), 1);

    // Wrap: 32 writes with the reader one behind.
    applyReset();
    prevGray = write_addr_gray;
    for (int i = 0; i < 32; i++) begin
      rp = (m_wcnt > 0) ? m_wcnt - 1 : 0;
      applyStimulus(1, rp, acc);
      checkOutput("wrap_step", int'($countones(prevGray ^ write_addr_gray) <= 1), 1);
      checkOutput("wrap_nofull", int'(flag_full), 0);
      prevGray = write_addr_gray;
    end
    checkOutput("wrap_gray0", int'(write_addr_gray), 0);

    // Same cycle: last slot written while the read pointer advances.
    applyReset();
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, acc);
    applyStimulus(0, 0, acc);
    applyStimulus(1, 1, acc);
    checkOutput("same_accept", int'(acc), 1);
    checkOutput("same_full_a", int'(flag_full), 1);
    applyStimulus(0, 1, acc);
    checkOutput("same_full_b", int'(flag_full), 1);
    applyStimulus(0, 1, acc);
    checkOutput("same_full_c", int'(flag_full), 0);
    checkOutput("same_noovf", int'(flag_overflow), 0);

    // Mid-burst asynchronous reset at pointer 7.
    applyReset();
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, acc);
    checkOutput("mid_pre_addr", int'(write_addr), 7);
    @(negedge w_clk);
    w_en = 1'b1;
    #2;
    w_rst_n = 1'b0;
    #1;
    checkOutput("mid_addr", int'(write_addr), 0);
    checkOutput("mid_gray", int'(write_addr_gray), 0);
    checkOutput("mid_full", int'(flag_full), 0);
    checkOutput("mid_ovf", int'(flag_overflow), 0);
    checkOutput("mid_accept", int'(w_accept), 1);
    m_wcnt = 0; m_sync[0] = 0; m_sync[1] = 0;
    m_full = 0; m_ovf = 0; m_af = 0;
    @(negedge w_clk);
    w_en    = 1'b0;
    w_rst_n = 1'b1;
    checkOutput("mid_rel_addr", int'(write_addr), 0);
    applyStimulus(1, 0, acc);
    checkOutput("mid_rel_accept", int'(acc), 1);

    // Random traffic; the reader never passes what has been written.
    applyReset();
    rp = 0;
    for (int i = 0; i < 400; i++) begin
      if (occupancy(m_wcnt, rp) != 0 && $urandom_range(0, 1) == 1) rp = (rp + 1) % 32;
      applyStimulus($urandom_range(0, 9) < 7, rp, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
